// File: rtl/zbuf_pkg.sv
// Shared types and constants for the Z-buffer line writer: point layout,
// writer FSM states and the depth RAM clear value.
package zbuf_pkg;

   localparam int X_W_DEF = 8;
   localparam int Y_W_DEF = 8;
   localparam int Z_W_DEF = 8;

   // Clear value for the depth RAM: farthest possible depth.
   localparam logic [Z_W_DEF-1:0] DEPTH_FAR = '1;

   typedef struct packed {
      logic [X_W_DEF-1:0] x;
      logic [Y_W_DEF-1:0] y;
      logic [Z_W_DEF-1:0] z;
   } point_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RD,
      ST_CMP,
      ST_WR,
      ST_REL,
      ST_DONE
   } wr_state_e;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter with synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/zbuf_line_writer.sv
// Pulls points from the line generator over a four-phase req/ack handshake,
// depth-tests each against the Z-buffer and writes strictly closer depths.
module zbuf_line_writer
   import zbuf_pkg::*;
#(
   parameter int X_W   = 8,
   parameter int Y_W   = 8,
   parameter int Z_W   = 8,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   req,
   input  logic                   ack,
   input  logic                   eol,
   input  logic [X_W+Y_W+Z_W-1:0] point_in,
   output logic [X_W+Y_W-1:0]     mem_addr,
   output logic                   mem_rd,
   input  logic [Z_W-1:0]         mem_rdata,
   output logic                   mem_wr,
   output logic [Z_W-1:0]         mem_wdata,
   output logic [CNT_W-1:0]       wr_cnt,
   output logic [CNT_W-1:0]       rej_cnt
);

   localparam int P_W = X_W + Y_W + Z_W;

   wr_state_e      state_q, state_d;
   logic [X_W-1:0] pt_x_q, pt_x_d;
   logic [Y_W-1:0] pt_y_q, pt_y_d;
   logic [Z_W-1:0] pt_z_q, pt_z_d;
   logic           last_q, last_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           cnt_clr;
   logic           wr_inc;
   logic           rej_inc;

   always_comb begin
      state_d = state_q;
      pt_x_d  = pt_x_q;
      pt_y_d  = pt_y_q;
      pt_z_d  = pt_z_q;
      last_d  = last_q;
      cnt_clr = 1'b0;
      wr_inc  = 1'b0;
      rej_inc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_clr = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack) begin
               pt_x_d  = point_in[P_W-1 -: X_W];
               pt_y_d  = point_in[Y_W+Z_W-1 -: Y_W];
               pt_z_d  = point_in[Z_W-1:0];
               last_d  = eol;
               state_d = ST_RD;
            end
         end
         ST_RD:   state_d = ST_CMP;
         // Equal depth rejects so the first-drawn point keeps the pixel.
         ST_CMP: begin
            if (pt_z_q < mem_rdata) begin
               state_d = ST_WR;
            end else begin
               rej_inc = 1'b1;
               state_d = last_q ? ST_DONE : ST_REL;
            end
         end
         ST_WR: begin
            wr_inc  = 1'b1;
            state_d = last_q ? ST_DONE : ST_REL;
         end
         ST_REL: begin
            if (!ack) begin
               state_d = ST_REQ;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pt_x_q  <= '0;
         pt_y_q  <= '0;
         pt_z_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pt_x_q  <= pt_x_d;
         pt_y_q  <= pt_y_d;
         pt_z_q  <= pt_z_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_wr_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr   (cnt_clr),
      .inc   (wr_inc),
      .q     (wr_cnt)
   );

   sat_counter #(.W(CNT_W)) u_rej_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr   (cnt_clr),
      .inc   (rej_inc),
      .q     (rej_cnt)
   );

   // Strobes come straight from the state so a reset kills them at once.
   assign req       = (state_q == ST_REQ);
   assign mem_rd    = (state_q == ST_RD);
   assign mem_wr    = (state_q == ST_WR);
   assign mem_addr  = {pt_y_q, pt_x_q};
   assign mem_wdata = pt_z_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_zbuf_line_writer.sv
// Self-checking bench for zbuf_line_writer: behavioural generator, depth RAM
// and a reference depth-test model operating on whole lines.
module tb_zbuf_line_writer;
   import zbuf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, req;
   logic        ack;
   logic        eol;
   logic [23:0] point_in;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [15:0] wr_cnt, rej_cnt;

   always #5 clk = ~clk;

   zbuf_line_writer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .req       (req),
      .ack       (ack),
      .eol       (eol),
      .point_in  (point_in),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .wr_cnt    (wr_cnt),
      .rej_cnt   (rej_cnt)
   );

   logic [7:0] ram     [0:65535];
   logic [7:0] ref_ram [0:65535];

   int vectors     = 0;
   int miscompares = 0;

   int  wr_pulses = 0;
   int  captures  = 0;
   int  viol      = 0;
   logic rd_prev, wr_prev, req_prev, ack_prev;

   // Depth RAM with one-cycle read latency
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
   end

   // Protocol monitor
   always @(posedge clk) begin
      if (!rst) begin
         rd_prev  <= 1'b0;
         wr_prev  <= 1'b0;
         req_prev <= 1'b0;
         ack_prev <= 1'b0;
      end else begin
         if (mem_rd && mem_wr) viol <= viol + 1;
         if ((mem_rd && rd_prev) || (mem_wr && wr_prev)) viol <= viol + 1;
         if (req && !req_prev && ack_prev) viol <= viol + 1;
         if (mem_wr) wr_pulses <= wr_pulses + 1;
         if (req && ack) captures <= captures + 1;
         rd_prev  <= mem_rd;
         wr_prev  <= mem_wr;
         req_prev <= req;
         ack_prev <= ack;
      end
   end

   typedef struct {
      logic [23:0] pt;
      logic [7:0]  stored;
      bit          exp_wr;
   } vec_t;

   logic [23:0] line_q[$];
   int exp_w, exp_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_far();
      for (int i = 0; i < 65536; i++) begin
         ram[i]     <= DEPTH_FAR;
         ref_ram[i] = DEPTH_FAR;
      end
      @(negedge clk);
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] v);
      ram[a]     <= v;
      ref_ram[a] = v;
   endtask

   function automatic logic [15:0] addr_of(input logic [23:0] p);
      point_t q;
      q = p;
      return {q.y, q.x};
   endfunction

   // Evenly spaced points along the major axis, minor axis and depth rounded.
   task automatic make_line(input logic [23:0] p0, input logic [23:0] p1);
      point_t a, b;
      int dx, dy, dz, n, x, y, z;
      real f;
      a = p0;
      b = p1;
      dx = int'(b.x) - int'(a.x);
      dy = int'(b.y) - int'(a.y);
      dz = int'(b.z) - int'(a.z);
      n  = ((dx < 0 ? -dx : dx) > (dy < 0 ? -dy : dy)) ? (dx < 0 ? -dx : dx) : (dy < 0 ? -dy : dy);
      n  = n + 1;
      line_q.delete();
      for (int i = 0; i < n; i++) begin
         f = (n == 1) ? 0.0 : real'(i) / real'(n - 1);
         x = int'(a.x) + $rtoi($floor(real'(dx) * f + 0.5));
         y = int'(a.y) + $rtoi($floor(real'(dy) * f + 0.5));
         z = int'(a.z) + $rtoi($floor(real'(dz) * f + 0.5));
         line_q.push_back({x[7:0], y[7:0], z[7:0]});
      end
   endtask

   // Reference: closer depth wins, ties and farther points are rejected.
   task automatic model_line();
      point_t p;
      logic [15:0] a;
      exp_w = 0;
      exp_r = 0;
      foreach (line_q[i]) begin
         p = line_q[i];
         a = {p.y, p.x};
         if (p.z < ref_ram[a]) begin
            ref_ram[a] = p.z;
            exp_w++;
         end else begin
            exp_r++;
         end
      end
   endtask

   // Behavioural generator: serves line_q one point per request.
   task automatic run_line(input int hold, input bit mid_start, input bit do_start);
      int n, t;
      n = line_q.size();
      if (do_start) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         if (mid_start && i == 1) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         t = 0;
         while (!req && t < 60) begin
            @(negedge clk);
            t++;
         end
         if (!req) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
         end
         point_in = line_q[i];
         eol      = (i == n - 1);
         ack      = 1'b1;
         @(posedge clk);
         if (i != n - 1) begin
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               check("req_low_while_ack", {31'd0, req}, 32'd0);
            end
         end
         @(negedge clk);
         ack      = 1'b0;
         eol      = 1'($urandom_range(0, 1));
         point_in = 24'($urandom);
      end
      t = 0;
      while (!done && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic run_and_check(input string tag, input int hold, input bit mid_start);
      int base;
      model_line();
      base = wr_pulses;
      run_line(hold, mid_start, 1'b1);
      check({tag, "_wr_cnt"}, {16'd0, wr_cnt}, exp_w);
      check({tag, "_rej_cnt"}, {16'd0, rej_cnt}, exp_r);
      check({tag, "_wr_pulses"}, wr_pulses - base, exp_w);
      foreach (line_q[i]) begin
         check({tag, "_ram"}, {24'd0, ram[addr_of(line_q[i])]}, {24'd0, ref_ram[addr_of(line_q[i])]});
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   base_cap, t;
      point_t p0, p1;

      vecs[0] = '{24'h9090A0, 8'hFF, 1'b1};
      vecs[1] = '{24'h253509, 8'h09, 1'b0};
      vecs[2] = '{24'h25350A, 8'h09, 1'b0};
      vecs[3] = '{24'h010100, 8'h00, 1'b0};
      vecs[4] = '{24'h0202FE, 8'hFF, 1'b1};
      vecs[5] = '{24'h0303FF, 8'hFF, 1'b0};
      vecs[6] = '{24'h040400, 8'h01, 1'b1};
      vecs[7] = '{24'hFFFF7F, 8'h80, 1'b1};

      rst      = 1'b0;
      start    = 1'b0;
      ack      = 1'b0;
      eol      = 1'b0;
      point_in = 24'h0;
      fill_far();
      repeat (2) @(negedge clk);

      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      check("rst_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
      check("rst_counters", {wr_cnt, rej_cnt}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single written point, cycle by cycle
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_req", {30'd0, req, busy}, 32'h3);
      point_in = 24'h9090A0;
      eol      = 1'b1;
      ack      = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("rd_cycle", {15'd0, req, mem_rd, mem_wr, mem_addr}, {15'd0, 3'b010, 16'h9090});
      @(negedge clk);
      check("cmp_cycle", {30'd0, mem_rd, mem_wr}, 32'd0);
      @(negedge clk);
      check("wr_cycle", {7'd0, mem_wr, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h9090, 8'hA0});
      @(negedge clk);
      check("done_cycle", {14'd0, done, busy, wr_cnt}, {14'd0, 2'b11, 16'd1});
      check("done_rej", {16'd0, rej_cnt}, 32'd0);
      @(negedge clk);
      check("after_done", {30'd0, done, busy}, 32'd0);
      check("ram_written", {24'd0, ram[16'h9090]}, 32'hA0);

      // Table of single-point lines
      fill_far();
      for (int i = 0; i < 8; i++) begin
         poke(addr_of(vecs[i].pt), vecs[i].stored);
         line_q.delete();
         line_q.push_back(vecs[i].pt);
         run_line(0, 1'b0, 1'b1);
         check("tbl_wr_cnt", {16'd0, wr_cnt}, {31'd0, vecs[i].exp_wr});
         check("tbl_rej_cnt", {16'd0, rej_cnt}, {31'd0, !vecs[i].exp_wr});
         check("tbl_ram", {24'd0, ram[addr_of(vecs[i].pt)]},
               {24'd0, vecs[i].exp_wr ? vecs[i].pt[7:0] : vecs[i].stored});
      end

      // Equal then farther rejects on one line
      fill_far();
      poke(16'h3525, 8'h09);
      line_q = '{24'h253509, 24'h25350A};
      run_and_check("rej2", 0, 1'b0);
      check("rej2_count", {16'd0, rej_cnt}, 32'd2);

      // Full line on a far-filled RAM
      fill_far();
      make_line(24'h9090A0, 24'h253509);
      base_cap = captures;
      run_and_check("full", 0, 1'b0);
      check("full_all_written", {16'd0, wr_cnt}, line_q.size());
      check("full_captures", captures - base_cap, line_q.size());
      @(negedge clk);
      check("full_idle", {30'd0, done, busy}, 32'd0);

      // Slow ack release
      fill_far();
      make_line(24'h404010, 24'h434018);
      base_cap = captures;
      run_and_check("slow", 3, 1'b0);
      check("slow_captures", captures - base_cap, line_q.size());

      // start while busy is ignored, start after done clears counters
      make_line(24'h505020, 24'h525022);
      run_and_check("midstart", 1, 1'b1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_clears", {wr_cnt, rej_cnt}, 32'd0);
      line_q = '{24'h606030};
      model_line();
      run_line(0, 1'b0, 1'b0);
      check("restart_wr", {16'd0, wr_cnt}, exp_w);

      // Reset during WR
      fill_far();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      point_in = 24'h707010;
      eol      = 1'b1;
      ack      = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      t = 0;
      while (!mem_wr && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("reached_wr", {31'd0, mem_wr}, 32'd1);
      rst = 1'b0;
      #1;
      check("rst_mid_strobes", {28'd0, mem_wr, mem_rd, req, done}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_addr", {8'd0, mem_addr, mem_wdata}, 32'd0);
      check("rst_mid_cnt", {wr_cnt, rej_cnt}, 32'd0);
      repeat (2) @(negedge clk);
      check("rst_no_write", {24'd0, ram[16'h7070]}, 32'hFF);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", {30'd0, req, busy}, 32'd0);
      line_q = '{24'h707010};
      for (int i = 0; i < 65536; i++) ref_ram[i] = ram[i];
      run_and_check("post_rst", 0, 1'b0);

      // Randomized lines over a small overlapping region
      for (int l = 0; l < 15; l++) begin
         for (int k = 0; k < 8; k++) begin
            poke({8'($urandom_range(8'h40, 8'h47)), 8'($urandom_range(8'h40, 8'h47))}, 8'($urandom));
         end
         @(negedge clk);
         p0 = {8'($urandom_range(8'h40, 8'h47)), 8'($urandom_range(8'h40, 8'h47)), 8'($urandom)};
         p1 = {8'($urandom_range(8'h40, 8'h47)), 8'($urandom_range(8'h40, 8'h47)), 8'($urandom)};
         make_line(p0, p1);
         run_and_check("rand", $urandom_range(0, 2), 1'b0);
      end

      check("protocol_viol", viol, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/zbuf_line_writer.md
# zbuf_line_writer

Consumer end of the line generator's req/ack point handshake. It requests points one at a time from a `brensenham_line` instance, depth-tests each point against a Z-buffer memory, and writes the point's depth when it is strictly closer. It sits between the line generator and the depth RAM, runs one line per `start`, and reports completion plus written/rejected counts to the triangle-level controller.

## Interface
- `X_W`, default 8: x coordinate width (`point_in[23:16]`).
- `Y_W`, default 8: y coordinate width (`point_in[15:8]`).
- `Z_W`, default 8: depth width (`point_in[7:0]`).
- `CNT_W`, default 16: statistics counter width.

- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin consuming one line; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is exited.
- `done` out 1: one-cycle pulse after the last point completes.
- `req` out 1: point request to the generator.
- `ack` in 1: point valid from the generator.
- `eol` in 1: qualified by `ack`; marks the current point as the last one.
- `point_in` in X_W+Y_W+Z_W: {x,y,z} of the generator's current point.
- `mem_addr` out X_W+Y_W: depth RAM address, {y,x}.
- `mem_rd` out 1: read strobe.
- `mem_rdata` in Z_W: stored depth, valid exactly 1 cycle after `mem_rd`.
- `mem_wr` out 1: write strobe.
- `mem_wdata` out Z_W: depth to write.
- `wr_cnt` out CNT_W: points written since the last accepted `start`.
- `rej_cnt` out CNT_W: points rejected since the last accepted `start`.

## Operation
- States: IDLE, REQ, RD, CMP, WR, REL, DONE.
- IDLE:
  - `req` is 0.
  - On `start=1`: clear both counters and go to REQ.
- REQ:
  - `req` is 1.
  - On `ack=1`: register `point_in` into `pt` and `eol` into `last`, then go to RD.
- RD:
  - `req` is 0, `mem_rd` is 1, `mem_addr` is {pt.y, pt.x}.
  - Next state is CMP.
- CMP:
  - `mem_rdata` is valid this cycle.
  - If `pt.z < mem_rdata` (unsigned, strict): go to WR.
  - Otherwise: increment `rej_cnt`. If `last`, go to DONE, else go to REL.
- WR:
  - `mem_wr` is 1, `mem_addr` is {pt.y, pt.x}, `mem_wdata` is `pt.z`.
  - Increment `wr_cnt`. If `last`, go to DONE, else go to REL.
- REL (four-phase return-to-zero):
  - `req` is 0. Wait for `ack=0`, then go to REQ.
  - If `ack` is already 0, this state lasts exactly 1 cycle.
- DONE:
  - `done` is 1 for one cycle, then go to IDLE.
  - `ack` is not waited low here; the generator is re-armed by its own `init`.
- Counters saturate at all-ones and never wrap.
- `start` while not in IDLE is ignored; there is no queueing.
- `eol` is ignored unless it is sampled together with `ack=1` in REQ.
- Equal depth is a reject; the first-drawn point wins.

## Timing
- Reset (asynchronous, `rst=0`): state IDLE; `req`, `busy`, `done`, `mem_rd` and `mem_wr` are 0; `mem_addr` and `mem_wdata` are 0; `pt`, `last` and both counters are 0.
- Reset asserted mid-line: everything returns to the values above immediately. Any in-flight write is abandoned and no strobe is emitted after reset.
- Start latency: `start` is sampled at edge N, then `req` and `busy` are 1 from edge N+1.
- `req` stays high until `ack` is sampled high. `req` is low in the cycle after that capture.
- Point throughput with `ack` low on return: REQ(≥1), RD, CMP, WR/skip, REL → at least 5 cycles per written point and 4 per rejected point.
- `mem_rd` and `mem_wr` are never high in the same cycle, and each is a single-cycle pulse.
- `done` rises 1 cycle after the last WR, or after the last CMP when that point is rejected. `busy` falls in the same cycle `done` falls.
- All outputs are registered, except that `req`, `mem_rd` and `mem_wr` are decoded from the registered state with no input dependence.

## Structure
- Shared package `zbuf_pkg` holds:
  - `point_t` packed struct {x,y,z} using the X_W/Y_W/Z_W defaults.
  - The `wr_state_e` enum.
  - `DEPTH_FAR` constant (all-ones), the clear value for the depth RAM.
- One sub-module, `sat_counter`: parameterised width, with `clr`, `inc` and a saturating `q`; instantiated twice.
- The FSM and datapath live in a single `always_ff` with an async-low reset, plus combinational output decode.

## Test plan
- Single written point:
  - Stimulus: RAM pre-filled with 0xFF; `start`; generator acks `point_in=0x9090A0` with `eol=1`.
  - Response: `mem_rd` with addr 0x9090, then `mem_wr` with addr 0x9090 and data 0xA0; `done` pulse; `wr_cnt=1`, `rej_cnt=0`.
- Rejects, equal and farther:
  - Stimulus: RAM[0x3525]=0x09; points 0x253509 then 0x25350A with `eol` on the second.
  - Response: both rejected, no `mem_wr`, `rej_cnt=2`.
- Full line against a behavioural generator:
  - Stimulus: line 0x9090A0→0x253509 on a 0xFF-filled RAM.
  - Response: one `mem_wr` per generated point; `wr_cnt` equals the point count; `req` never reasserts while `ack=1`.
- Slow ack release:
  - Stimulus: generator holds `ack` high 3 extra cycles after capture.
  - Response: block stays in REL; `req` stays 0 until `ack` falls; exactly one capture per point.
- `start` while busy, then a second line:
  - Stimulus: pulse `start` mid-line.
  - Response: ignored, counters untouched. A `start` after `done` clears the counters to 0.
- Reset mid-line:
  - Stimulus: drop `rst` during the WR state.
  - Response: `mem_wr` goes to 0 immediately; all outputs hold their reset values; the block is IDLE after `rst` rises; a new `start` works.
